des_iterative_sequencer: RTL and testbench
==========================================

DES_ITERATIVE_SEQUENCER -- requirements
Module: des_iterative_sequencer

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a job (data_in, key, decrypt) is presented.
REQ-005 in_ready  output  1  the block accepts a job this cycle.
REQ-006 data_in  input  64 [1:64]  plaintext or ciphertext block, bit 1 = MSB (DES numbering).
REQ-007 key  input  64 [1:64]  DES key; parity bits 8,16,...,64 are ignored.
REQ-008 decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with the job.
REQ-009 out_valid  output  1  data_out holds a finished result.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 data_out  output  64 [1:64]  result block, registered.
REQ-012 busy  output  1  high in ROUND and DONE.
REQ-013 round_idx  output  4  index of the round executing next, 0..15.

Function
REQ-014 The block SHALL time-share one instance of the team's 32-bit Feistel round datapath (E-expansion, 48-bit key XOR, S1..S8, P, XOR with L) across 16 iterations.
REQ-015 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL load {L,R}=IP(data_in), latch decrypt, load {C,D}=PC-1(key), set round_idx=0 and go to ROUND.
REQ-017 The round key for each iteration SHALL be PC-2 applied to the current {C,D}, after the per-round rotation.
REQ-018 Encrypt rotation: C and D SHALL each rotate left by {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}[round_idx] before PC-2.
REQ-019 Decrypt rotation: round 0 SHALL apply no rotation; rounds 1..15 SHALL rotate C and D right by {1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}[round_idx-1], so the keys are produced in the order K16..K1.
REQ-020 ROUND, each cycle: the block SHALL apply L<=R, R<=L^f(R,K) and round_idx<=round_idx+1.
REQ-021 After the iteration with round_idx=15, the block SHALL register data_out=FP({R,L}) (final swap, then inverse IP), set out_valid=1, set round_idx to 0 and go to DONE.
REQ-022 Latency: out_valid SHALL rise exactly 16 clock edges after the accepting edge.
REQ-023 DONE: out_valid and data_out SHALL stay stable until out_valid&&out_ready.
REQ-024 On out_valid&&out_ready the block SHALL clear out_valid and go to IDLE.
REQ-025 in_ready SHALL be 0 in DONE, so there is no same-cycle accept; maximum throughput is one block per 18 cycles with out_ready held high.
REQ-026 Changes to in_valid, data_in, key or decrypt during ROUND or DONE SHALL have no effect.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 On reset_n=0, regardless of clk, the block SHALL immediately force state=IDLE, out_valid=0, data_out=0, round_idx=0, busy=0 and clear L, R, C and D.
REQ-029 Reset during ROUND or DONE SHALL abort the job and produce no out_valid pulse.
REQ-030 While reset_n=0, in_ready SHALL be 0; in_ready SHALL become 1 at the first clk edge after reset_n deasserts.

Verification
REQ-031 Encrypt: key=133457799BBCDFF1, data_in=0123456789ABCDEF, decrypt=0 -> data_out=85E813540F0AB405, with out_valid 16 edges after accept.
REQ-032 Decrypt round-trip: key=133457799BBCDFF1, data_in=85E813540F0AB405, decrypt=1 -> data_out=0123456789ABCDEF.
REQ-033 Encrypt: key=0E329232EA6D0D73, data_in=8787878787878787 -> data_out=0000000000000000; flipping any key parity bit gives the same result.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> data_out stable, in_ready=0 and a new in_valid ignored; then out_ready=1 -> IDLE on the next edge, and in_ready=1.
REQ-035 Reset abort: assert reset_n=0 when round_idx=7 -> out_valid=0, busy=0 and round_idx=0 at once; a new job after release gives the correct result.
REQ-036 Back-to-back: keep in_valid and out_ready high for 3 jobs -> 3 correct results, accepts spaced 18 cycles apart, and round_idx steps 0..15 for each job.

Source files
------------

// File: rtl/des_iterative_sequencer.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds per block,
// with an on-the-fly key schedule that runs forwards for encrypt and backwards for decrypt.
module des_iterative_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy,
    output logic [3:0]  round_idx
);
    // Vector bit [W-1] is DES bit 1; tables hold 1-based DES bit numbers.
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // S1..S8, each 4 rows x 16 columns, row-major.
    localparam int S_TAB [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    function automatic logic [63:0] perm_ip(input logic [63:0] v);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - IP_TAB[6'(i)])];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] v);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - FP_TAB[6'(i)])];
        return o;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] v);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = v[5'(32 - E_TAB[6'(i)])];
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] v);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = v[5'(32 - P_TAB[5'(i)])];
        return o;
    endfunction

    // Parity bits of the key simply never get selected.
    function automatic logic [55:0] perm_pc1(input logic [63:0] v);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = v[6'(64 - PC1_TAB[6'(i)])];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] v);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = v[6'(56 - PC2_TAB[6'(i)])];
        return o;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] l_reg, l_next, r_reg, r_next;
    logic [27:0] c_reg, c_next, d_reg, d_next;
    logic [3:0]  idx_reg, idx_next;
    logic        dec_reg, dec_next;
    logic        out_valid_reg, out_valid_next;
    logic [63:0] data_out_reg, data_out_next;
    logic        ready_reg;

    logic [27:0] c_rot, d_rot;
    logic        one_shift;
    logic [47:0] subkey, x_bits;
    logic [31:0] s_out, f_out;
    logic [63:0] ip_out, fp_out;
    logic [55:0] pc1_out;

    // Decrypt walks the schedule backwards: K16 is the unrotated PC-1 state.
    always_comb begin
        if (dec_reg)
            one_shift = (idx_reg == 4'd1) || (idx_reg == 4'd8) || (idx_reg == 4'd15);
        else
            one_shift = (idx_reg == 4'd0) || (idx_reg == 4'd1) || (idx_reg == 4'd8) ||
                        (idx_reg == 4'd15);
        c_rot = c_reg;
        d_rot = d_reg;
        if (dec_reg && idx_reg != 4'd0) begin
            c_rot = one_shift ? {c_reg[0], c_reg[27:1]} : {c_reg[1:0], c_reg[27:2]};
            d_rot = one_shift ? {d_reg[0], d_reg[27:1]} : {d_reg[1:0], d_reg[27:2]};
        end else if (!dec_reg) begin
            c_rot = one_shift ? {c_reg[26:0], c_reg[27]} : {c_reg[25:0], c_reg[27:26]};
            d_rot = one_shift ? {d_reg[26:0], d_reg[27]} : {d_reg[25:0], d_reg[27:26]};
        end
    end

    assign subkey  = perm_pc2({c_rot, d_rot});
    assign x_bits  = perm_e(r_reg) ^ subkey;
    assign f_out   = perm_p(s_out);
    assign ip_out  = perm_ip(data_in);
    assign pc1_out = perm_pc1(key);
    assign fp_out  = perm_fp({l_reg ^ f_out, r_reg});

    // Row comes from the outer two bits of each 6-bit group, column from the inner four.
    for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
        logic [5:0] six;
        logic [8:0] sidx;
        assign six  = x_bits[47 - 6*gi -: 6];
        assign sidx = {3'(gi), six[5], six[0], six[4:1]};
        assign s_out[31 - 4*gi -: 4] = 4'(S_TAB[sidx]);
    end

    always_comb begin
        state_next     = state_reg;
        l_next         = l_reg;
        r_next         = r_reg;
        c_next         = c_reg;
        d_next         = d_reg;
        idx_next       = idx_reg;
        dec_next       = dec_reg;
        out_valid_next = out_valid_reg;
        data_out_next  = data_out_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    {l_next, r_next} = ip_out;
                    {c_next, d_next} = pc1_out;
                    dec_next         = decrypt;
                    idx_next         = 4'd0;
                    state_next       = ROUND;
                end
            end
            ROUND: begin
                l_next   = r_reg;
                r_next   = l_reg ^ f_out;
                c_next   = c_rot;
                d_next   = d_rot;
                idx_next = idx_reg + 4'd1;
                if (idx_reg == 4'd15) begin
                    data_out_next  = fp_out;
                    out_valid_next = 1'b1;
                    idx_next       = 4'd0;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            l_reg         <= '0;
            r_reg         <= '0;
            c_reg         <= '0;
            d_reg         <= '0;
            idx_reg       <= '0;
            dec_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            data_out_reg  <= '0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            l_reg         <= l_next;
            r_reg         <= r_next;
            c_reg         <= c_next;
            d_reg         <= d_next;
            idx_reg       <= idx_next;
            dec_reg       <= dec_next;
            out_valid_reg <= out_valid_next;
            data_out_reg  <= data_out_next;
            ready_reg     <= 1'b1;
        end
    end

    // ready_reg holds in_ready low until the first edge after reset release.
    assign in_ready  = ready_reg && (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;
    assign round_idx = idx_reg;

endmodule

// File: tb/tb_des_iterative_sequencer.sv
// Directed bench for des_iterative_sequencer: known-answer DES vectors checked
// through an expected-result queue, plus latency, backpressure, reset-abort and back-to-back cases.
module tb_des_iterative_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic [63:0] key;
    logic        decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
    logic        busy;
    logic [3:0]  round_idx;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];

    typedef struct {
        logic [63:0] din;
        logic [63:0] k;
        logic        dec;
        logic [63:0] expv;
    } job_t;
    job_t jobs [$];

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT = 64'h85E813540F0AB405;

    always #5 clk = ~clk;

    des_iterative_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key       (key),
        .decrypt   (decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy),
        .round_idx (round_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic score(input string tag);
        logic [63:0] expv;
        check({tag, "_queued"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            expv = sb.pop_front();
            check(tag, data_out, expv);
        end
    endtask

    // Runs one job; junk is driven on the inputs while the job is in flight.
    task automatic do_job(input string tag, input logic [63:0] din, input logic [63:0] k,
                          input logic dec, input logic [63:0] expv, input int stall);
        int n;
        data_in   = din;
        key       = k;
        decrypt   = dec;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        tick();
        sb.push_back(expv);
        data_in = ~din;
        key     = ~k;
        decrypt = ~dec;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_idx0"}, 64'(round_idx), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
            if (!out_valid && n < 16) check({tag, "_idx"}, 64'(round_idx), 64'(n));
        end
        check({tag, "_latency"}, 64'(n), 64'd16);
        check({tag, "_idx_done"}, 64'(round_idx), 64'd0);
        score({tag, "_data"});
        $display("job %s din=%h key=%h dec=%0d -> data_out=%h (expected %h)",
                 tag, din, k, dec, data_out, expv);
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "_hold_data"}, data_out, expv);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_release_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_release_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n, acc, got, since, cyc, last_acc;
        logic seen, acc_now;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        key       = '0;
        decrypt   = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_round_idx", 64'(round_idx), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        #1;
        check("release_in_ready_pre_edge", 64'(in_ready), 64'd0);
        tick();
        check("release_in_ready", 64'(in_ready), 64'd1);
        $display("reset released, in_ready=%0d", in_ready);

        do_job("enc_kat", PT, K1, 1'b0, CT, 0);
        do_job("dec_kat", CT, K1, 1'b1, PT, 0);
        do_job("enc_k2", 64'h8787878787878787, K2, 1'b0, 64'h0, 0);
        do_job("enc_k2_parity_all", 64'h8787878787878787, 64'h0F339333EB6C0C72, 1'b0, 64'h0, 0);
        do_job("enc_k2_parity_b64", 64'h8787878787878787, 64'h0E329232EA6D0D72, 1'b0, 64'h0, 0);
        do_job("enc_k1_parity_b8", PT, 64'h123457799BBCDFF1, 1'b0, CT, 0);
        do_job("dec_k2", 64'h0, K2, 1'b1, 64'h8787878787878787, 0);
        do_job("backpressure", PT, K1, 1'b0, CT, 10);

        // Abort a job mid-flight with an asynchronous reset.
        data_in   = PT;
        key       = K1;
        decrypt   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd7 && n < 30) begin
            tick();
            n++;
        end
        check("abort_reached_7", 64'(round_idx), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_round_idx", 64'(round_idx), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        $display("reset asserted mid-job: busy=%0d round_idx=%0d", busy, round_idx);
        tick();
        tick();
        check("abort_in_ready_held", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_pulse", 64'(seen), 64'd0);
        check("abort_ready_after", 64'(in_ready), 64'd1);
        do_job("after_abort", PT, K1, 1'b0, CT, 0);

        // Back-to-back: in_valid and out_ready held high across three jobs.
        jobs.push_back('{din: PT, k: K1, dec: 1'b0, expv: CT});
        jobs.push_back('{din: CT, k: K1, dec: 1'b1, expv: PT});
        jobs.push_back('{din: 64'h0, k: K2, dec: 1'b1, expv: 64'h8787878787878787});
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = jobs[0].din;
        key       = jobs[0].k;
        decrypt   = jobs[0].dec;
        acc = 0;
        got = 0;
        since = 100;
        cyc = 0;
        last_acc = 0;
        while (got < 3 && cyc < 200) begin
            acc_now = in_ready && in_valid;
            tick();
            cyc++;
            if (acc_now) begin
                sb.push_back(jobs[acc].expv);
                if (acc > 0) check("b2b_spacing", 64'(cyc - last_acc), 64'd18);
                check("b2b_idx0", 64'(round_idx), 64'd0);
                last_acc = cyc;
                acc++;
                since = 0;
                if (acc < 3) begin
                    data_in = jobs[acc].din;
                    key     = jobs[acc].k;
                    decrypt = jobs[acc].dec;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                since++;
                if (out_valid) begin
                    check("b2b_latency", 64'(since), 64'd16);
                    score("b2b_data");
                    $display("b2b result %0d data_out=%h at cycle %0d", got, data_out, cyc);
                    got++;
                end else if (since <= 15) begin
                    check("b2b_idx", 64'(round_idx), 64'(since));
                end
            end
        end
        check("b2b_count", 64'(got), 64'd3);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
